// File: rtl/dct_pkg.sv
// Shared DCT datapath constants, payload types and sign-magnitude/two's-complement helpers.
package dct_pkg;

    localparam int unsigned MAG_W   = 32;
    localparam int unsigned N_TERMS = 8;
    localparam int unsigned CNT_W   = $clog2(N_TERMS);
    localparam int unsigned SUM_W   = MAG_W + CNT_W;
    localparam int unsigned OUT_W   = SUM_W + 1;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_prod_t;

    typedef struct packed {
        logic             sign;
        logic [SUM_W-1:0] mag;
    } sm_sum_t;

    typedef logic signed [OUT_W-1:0] tc_t;

    // Negative zero maps to plain zero.
    function automatic tc_t sm_to_tc(input logic sign, input logic [MAG_W-1:0] mag);
        tc_t ext;
        ext = tc_t'({{(OUT_W - MAG_W){1'b0}}, mag});
        return (sign && (mag != '0)) ? -ext : ext;
    endfunction

    // A zero value always comes back with sign 0.
    function automatic sm_sum_t tc_to_sm(input tc_t value);
        sm_sum_t r;
        tc_t     abs_v;
        abs_v  = value[OUT_W-1] ? -value : value;
        r.sign = value[OUT_W-1];
        r.mag  = abs_v[SUM_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/dct_sm_accumulator_if.sv
// Product-in / coefficient-out valid-ready bus of the DCT accumulator.
interface dct_sm_accumulator_if;
    import dct_pkg::*;

    logic     in_valid;
    logic     in_ready;
    sm_prod_t in_data;
    logic     out_valid;
    logic     out_ready;
    sm_sum_t  out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/dct_sm_to_tc.sv
// Combinational sign-magnitude product to accumulator-width two's complement.
module dct_sm_to_tc
    import dct_pkg::*;
(
    input  sm_prod_t prod_i,
    output tc_t      term_o
);

    assign term_o = sm_to_tc(prod_i.sign, prod_i.mag);

endmodule

// File: rtl/dct_sm_accumulator.sv
// Sums N_TERMS sign-magnitude products into one sign-magnitude DCT coefficient.
module dct_sm_accumulator
    import dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    dct_sm_accumulator_if.slave  bus
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    tc_t              acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    sm_sum_t          out_data_q, out_data_d;

    tc_t  term_c;
    tc_t  sum_c;
    logic last_c;
    logic in_ready_c;
    logic in_fire_c;
    logic out_fire_c;

    dct_sm_to_tc u_sm_to_tc (
        .prod_i (bus.in_data),
        .term_o (term_c)
    );

    assign sum_c  = acc_q + term_c;
    assign last_c = (cnt_q == CNT_W'(N_TERMS - 1));

    // Only the completing term stalls, and only when the result slot cannot free up.
    assign in_ready_c = !clear && !(last_c && out_valid_q && !bus.out_ready);
    assign in_fire_c  = bus.in_valid && in_ready_c;
    assign out_fire_c = out_valid_q && bus.out_ready;

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_fire_c) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (in_fire_c) begin
            if (last_c) begin
                out_data_d  = tc_to_sm(sum_c);
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = sum_c;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_dct_sm_accumulator.sv
// Scoreboard bench for dct_sm_accumulator: grouping, stalls, clear and async reset.
module tb_dct_sm_accumulator;
    import dct_pkg::*;

    logic clk;
    logic rst_n;
    logic clear;
    int   cyc;

    int n_tests;
    int n_fail;

    logic [OUT_W-1:0] sb[$];
    longint           m_acc;
    int               m_cnt;

    dct_sm_accumulator_if bus ();

    dct_sm_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] exp_sm(input longint v);
        if (v < 0) return {1'b1, SUM_W'(-v)};
        return {1'b0, SUM_W'(v)};
    endfunction

    // Mirror of an accepted term in the bench's own arithmetic.
    task automatic model_accept(input logic s, input logic [MAG_W-1:0] m);
        longint t;
        t = s ? -longint'(m) : longint'(m);
        m_acc += t;
        m_cnt++;
        if (m_cnt == int'(N_TERMS)) begin
            sb.push_back(exp_sm(m_acc));
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_term(input logic s, input logic [MAG_W-1:0] m);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = '{sign: s, mag: m};
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        model_accept(s, m);
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_group(input logic s, input logic [MAG_W-1:0] m);
        for (int i = 0; i < int'(N_TERMS); i++) drive_term(s, m);
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                chk("out_data", 64'(bus.out_data), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic signed [MAG_W:0] g2 [8];
        n_tests = 0;
        n_fail  = 0;
        m_acc   = 0;
        m_cnt   = 0;
        rst_n   = 1'b0;
        clear   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Mixed group with a negative zero, back-to-back.
        t0 = cyc;
        drive_term(1'b0, 32'd10);
        drive_term(1'b0, 32'd20);
        drive_term(1'b1, 32'd5);
        drive_term(1'b0, 32'd0);
        drive_term(1'b1, 32'd0);
        drive_term(1'b0, 32'd7);
        drive_term(1'b1, 32'd2);
        drive_term(1'b0, 32'd1);
        chk("throughput_cycles", 64'(cyc - t0), 64'(N_TERMS));
        chk("latency_valid", 64'(bus.out_valid), 64'd1);
        chk("mixed_sum", 64'(bus.out_data), 64'({1'b0, SUM_W'(31)}));
        @(posedge clk);
        #1;
        chk("single_pulse", 64'(bus.out_valid), 64'd0);

        // Full-scale negative group.
        drive_group(1'b1, 32'hFFFF_FFFF);
        chk("neg_full", 64'(bus.out_data), 64'({1'b1, SUM_W'(35'h7_FFFF_FFF8)}));
        wait_drain();

        // Cancelling terms give positive zero.
        drive_term(1'b0, 32'd3);
        drive_term(1'b1, 32'd3);
        for (int i = 0; i < 6; i++) drive_term(1'b0, 32'd0);
        chk("zero_sum", 64'(bus.out_data), 64'd0);
        wait_drain();

        // Back-pressure: completing term of group 2 waits for the drain of group 1.
        bus.out_ready = 1'b0;
        drive_group(1'b0, 32'd5);
        g2 = '{33'sd1000, -33'sd1, 33'sd2, -33'sd3, 33'sd4, -33'sd5, 33'sd6, 33'sd7};
        for (int i = 0; i < 7; i++)
            drive_term(g2[i] < 0, MAG_W'(g2[i] < 0 ? -g2[i] : g2[i]));
        bus.in_valid = 1'b1;
        bus.in_data  = '{sign: 1'b0, mag: 32'd7};
        @(negedge clk);
        chk("stall_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_ready2", 64'(bus.in_ready), 64'd0);
        chk("stall_hold", 64'(bus.out_data), 64'({1'b0, SUM_W'(40)}));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("drain_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        model_accept(1'b0, 32'd7);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("refill_valid", 64'(bus.out_valid), 64'd1);
        chk("refill_data", 64'(bus.out_data), 64'({1'b0, SUM_W'(1010)}));
        wait_drain();

        // Clear aborts a partial group; nothing is taken during the clear cycle.
        for (int i = 0; i < 4; i++) drive_term(1'b0, 32'd100);
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = '{sign: 1'b0, mag: 32'd100};
        @(negedge clk);
        chk("clear_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        drive_group(1'b0, 32'd1);
        chk("after_clear", 64'(bus.out_data), 64'({1'b0, SUM_W'(8)}));
        wait_drain();

        // Clear with a pending result leaves it intact.
        bus.out_ready = 1'b0;
        drive_group(1'b0, 32'd9);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        chk("clear_keep_valid", 64'(bus.out_valid), 64'd1);
        chk("clear_keep_data", 64'(bus.out_data), 64'({1'b0, SUM_W'(72)}));
        wait_drain();

        // Asynchronous reset mid-group with a pending result.
        bus.out_ready = 1'b0;
        drive_group(1'b0, 32'd50);
        for (int i = 0; i < 5; i++) drive_term(1'b0, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_out_data", 64'(bus.out_data), 64'd0);
        sb.delete();
        m_acc = 0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drive_group(1'b1, 32'd4);
        chk("post_reset_sum", 64'(bus.out_data), 64'({1'b1, SUM_W'(32)}));
        wait_drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
